// File: rtl/pc_conditioner.sv
// pc_conditioner: front-end for the queue manager. Cleans two raw photocell beams
// (front = exit, back = entry) into one active-low pulse per debounced block event,
// and flags a beam that stays blocked too long.
// Channel 0 is the front beam and channel 1 is the back beam.
module pc_conditioner #(
    parameter int unsigned DB_CYCLES    = 4,
    parameter int unsigned PULSE_W      = 1,
    parameter int unsigned STUCK_CYCLES = 64,
    parameter int unsigned CNT_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic front_raw,
    input  logic back_raw,
    output logic frontPC,
    output logic backPC,
    output logic fault_front,
    output logic fault_back
);

    typedef enum logic [2:0] {
        StIdle,
        StQualLo,
        StPulse,
        StHeld,
        StStuck,
        StQualHi
    } state_e;

    localparam logic [CNT_W-1:0] DbLimit    = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] PulseLast  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] StuckLimit = CNT_W'(STUCK_CYCLES);

    logic [1:0] raw;
    logic [1:0] pc;
    logic [1:0] fault;

    assign raw = {back_raw, front_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic             s1_q;
        logic             s2_q;
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] cnt_inc;
        logic             out_q, out_d;
        logic             fault_q, fault_d;

        // Two-flop synchroniser; idles high (beam clear) out of reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_q <= 1'b1;
                s2_q <= 1'b1;
            end else begin
                s1_q <= raw[ch];
                s2_q <= s1_q;
            end
        end

        // Saturating increment so long blockages never wrap the counter.
        assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

        // State, counter and registered outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                out_q   <= 1'b1;
                fault_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                fault_q <= fault_d;
            end
        end

        // Next-state: debounce low, emit one pulse, watch for stuck, debounce high.
        // Entering a qualify state counts the triggering sample as the first one.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            out_d   = out_q;
            fault_d = fault_q;
            case (state_q)
                StIdle: begin
                    out_d = 1'b1;
                    if (!s2_q) begin
                        if (DB_CYCLES <= 1) begin
                            state_d = StPulse;
                            cnt_d   = '0;
                            out_d   = 1'b0;
                        end else begin
                            state_d = StQualLo;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                StQualLo: begin
                    if (s2_q) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_inc >= DbLimit) begin
                        state_d = StPulse;
                        cnt_d   = '0;
                        out_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StPulse: begin
                    if (cnt_q >= PulseLast) begin
                        state_d = StHeld;
                        cnt_d   = '0;
                        out_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StHeld, StStuck: begin
                    if (s2_q) begin
                        if (DB_CYCLES <= 1) begin
                            state_d = StIdle;
                            fault_d = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            state_d = StQualHi;
                            cnt_d   = CNT_W'(1);
                        end
                    end else if (state_q == StHeld) begin
                        if (cnt_inc >= StuckLimit) begin
                            state_d = StStuck;
                            cnt_d   = '0;
                            fault_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                StQualHi: begin
                    // A bounce on release returns to the blocked state without a pulse.
                    if (!s2_q) begin
                        state_d = fault_q ? StStuck : StHeld;
                        cnt_d   = '0;
                    end else if (cnt_inc >= DbLimit) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        fault_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    out_d   = 1'b1;
                    fault_d = 1'b0;
                end
            endcase
        end

        assign pc[ch]    = out_q;
        assign fault[ch] = fault_q;
    end

    assign frontPC     = pc[0];
    assign backPC      = pc[1];
    assign fault_front = fault[0];
    assign fault_back  = fault[1];

endmodule

// File: tb/tb_pc_conditioner.sv
// Bench for pc_conditioner: stimulus pushes expected output transitions (signal,
// value, cycle) into a queue; a monitor compares every observed transition.
module tb_pc_conditioner;

    typedef struct {
        int   sig;
        logic val;
        int   cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic front_raw;
    logic back_raw;
    logic frontPC;
    logic backPC;
    logic fault_front;
    logic fault_back;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    ev_t  exp_q[$];
    logic [3:0] prev = 4'b0011;

    pc_conditioner #(
        .DB_CYCLES   (4),
        .PULSE_W     (1),
        .STUCK_CYCLES(64),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .front_raw  (front_raw),
        .back_raw   (back_raw),
        .frontPC    (frontPC),
        .backPC     (backPC),
        .fault_front(fault_front),
        .fault_back (fault_back)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sname(input int s);
        case (s)
            0:       return "frontPC";
            1:       return "backPC";
            2:       return "fault_front";
            default: return "fault_back";
        endcase
    endfunction

    task automatic check(input string what, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b, required %b", what, act, req);
        end
    endtask

    task automatic expect_ev(input int s, input logic v, input int c);
        ev_t e;
        e.sig = s;
        e.val = v;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic compare_event(input int s, input logic v);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got %s=%b at cycle %0d, required no change",
                     sname(s), v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.sig != s || e.val !== v || e.cyc != cyc) begin
                bad++;
                $display("FAIL event: got %s=%b at cycle %0d, required %s=%b at cycle %0d",
                         sname(s), v, cyc, sname(e.sig), e.val, e.cyc);
            end
        end
    endtask

    // Monitor: any output transition seen away from the active edge is scored.
    always @(negedge clk) begin
        logic [3:0] now;
        now = {fault_back, fault_front, backPC, frontPC};
        for (int s = 0; s < 4; s++) begin
            if (now[s] !== prev[s]) compare_event(s, now[s]);
        end
        prev <= now;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        int n;
        rst       = 1'b1;
        front_raw = 1'b1;
        back_raw  = 1'b1;
        #1;
        check("reset_frontPC", frontPC, 1'b1);
        check("reset_backPC", backPC, 1'b1);
        check("reset_fault_front", fault_front, 1'b0);
        check("reset_fault_back", fault_back, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: back stuck, then reset lands on the cycle frontPC goes low.
        n = cyc;
        back_raw = 1'b0;
        expect_ev(1, 1'b0, n + 6);
        expect_ev(1, 1'b1, n + 7);
        expect_ev(3, 1'b1, n + 71);
        repeat (75) @(negedge clk);
        n = cyc;
        front_raw = 1'b0;
        expect_ev(3, 1'b0, n + 6);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        check("pre_reset_frontPC_low", frontPC, 1'b0);
        check("pre_reset_fault_back", fault_back, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("async_reset_frontPC", frontPC, 1'b1);
        check("async_reset_backPC", backPC, 1'b1);
        check("async_reset_fault_back", fault_back, 1'b0);
        @(negedge clk);
        front_raw = 1'b1;
        back_raw  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // 2: back low 20 cycles -> single backPC pulse after edge k+5.
        n = cyc;
        back_raw = 1'b0;
        expect_ev(1, 1'b0, n + 6);
        expect_ev(1, 1'b1, n + 7);
        repeat (20) @(negedge clk);
        back_raw = 1'b1;
        repeat (10) @(negedge clk);

        // 3: short glitch filtered.
        back_raw = 1'b0;
        repeat (3) @(negedge clk);
        back_raw = 1'b1;
        repeat (10) @(negedge clk);

        // 4: front low with bouncing release -> one pulse only.
        n = cyc;
        front_raw = 1'b0;
        expect_ev(0, 1'b0, n + 6);
        expect_ev(0, 1'b1, n + 7);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            front_raw = (i % 2 == 0);
            @(negedge clk);
        end
        front_raw = 1'b1;
        repeat (12) @(negedge clk);

        // 5: both beams together -> simultaneous pulses.
        n = cyc;
        front_raw = 1'b0;
        back_raw  = 1'b0;
        expect_ev(0, 1'b0, n + 6);
        expect_ev(1, 1'b0, n + 6);
        expect_ev(0, 1'b1, n + 7);
        expect_ev(1, 1'b1, n + 7);
        repeat (20) @(negedge clk);
        front_raw = 1'b1;
        back_raw  = 1'b1;
        repeat (10) @(negedge clk);

        // 6: front stuck 100 cycles, fault raise/clear, then a fresh pulse.
        n = cyc;
        front_raw = 1'b0;
        expect_ev(0, 1'b0, n + 6);
        expect_ev(0, 1'b1, n + 7);
        expect_ev(2, 1'b1, n + 71);
        expect_ev(2, 1'b0, n + 106);
        repeat (100) @(negedge clk);
        front_raw = 1'b1;
        repeat (12) @(negedge clk);
        n = cyc;
        front_raw = 1'b0;
        expect_ev(0, 1'b0, n + 6);
        expect_ev(0, 1'b1, n + 7);
        repeat (10) @(negedge clk);
        front_raw = 1'b1;
        repeat (12) @(negedge clk);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_events: got %0d expected transitions unseen, required 0",
                     exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
